// File: rtl/pe_custom_inport.sv
// ============================================================================
// Module   : pe_custom_inport
// Brief    : Receive side of the PE custom port. Detects flit arrivals from
//            toggles of the differential pair and buffers them in a FWFT FIFO
//            with a valid/ack head and one credit pulse per consumed flit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pe_custom_inport #(
  parameter int FLIT_WIDTH = 40,
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_WIDTH  = 2
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic [FLIT_WIDTH-1:0] channel_din,
  input  logic [1:0]            diff_pair_din,
  input  logic                  pe_ack_din,
  input  logic                  err_clear_din,
  output logic [FLIT_WIDTH-1:0] flit_dout,
  output logic                  flit_valid_dout,
  output logic                  credit_dout,
  output logic [PTR_WIDTH:0]    occupancy_dout,
  output logic                  overflow_dout,
  output logic                  line_error_dout
);

  localparam logic [1:0]         c_PAIR_IDLE = 2'b01;
  localparam logic [PTR_WIDTH:0] c_DEPTH     = (PTR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [PTR_WIDTH:0] c_PTR_ONE   = (PTR_WIDTH+1)'(1);

  logic [FLIT_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_WIDTH:0]    r_wr_ptr;
  logic [PTR_WIDTH:0]    r_rd_ptr;
  logic [PTR_WIDTH:0]    r_count;
  logic [1:0]            r_pair_q;
  logic                  r_valid;
  logic [FLIT_WIDTH-1:0] r_flit;
  logic                  r_credit;
  logic                  r_overflow;
  logic                  r_line_err;

  logic                  w_legal;
  logic                  w_arrival;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [PTR_WIDTH:0]    w_wr_ptr_nxt;
  logic [PTR_WIDTH:0]    w_rd_ptr_nxt;
  logic [PTR_WIDTH:0]    w_count_nxt;
  logic [PTR_WIDTH-1:0]  w_wr_idx;
  logic [PTR_WIDTH-1:0]  w_rd_idx_nxt;
  logic [FLIT_WIDTH-1:0] w_head_nxt;

  // Legal codes are exactly the two one-hot values; 00/11 are line faults.
  assign w_legal   = diff_pair_din[1] ^ diff_pair_din[0];
  assign w_arrival = w_legal && (diff_pair_din != r_pair_q);

  assign w_full = (r_count == c_DEPTH);
  assign w_pop  = pe_ack_din && r_valid;
  assign w_push = w_arrival && (!w_full || w_pop);
  assign w_drop = w_arrival && !w_push;

  assign w_wr_ptr_nxt = w_push ? (r_wr_ptr + c_PTR_ONE) : r_wr_ptr;
  assign w_rd_ptr_nxt = w_pop  ? (r_rd_ptr + c_PTR_ONE) : r_rd_ptr;
  // Extended pointers make the difference the exact occupancy, 0..DEPTH.
  assign w_count_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;

  assign w_wr_idx     = r_wr_ptr[PTR_WIDTH-1:0];
  assign w_rd_idx_nxt = w_rd_ptr_nxt[PTR_WIDTH-1:0];

  // The next head is the incoming flit only when it lands in the head slot,
  // i.e. it becomes the sole entry; otherwise it is already in storage.
  always_comb begin
    w_head_nxt = r_mem[w_rd_idx_nxt];
    if (w_push && (w_wr_idx == w_rd_idx_nxt)) begin
      w_head_nxt = channel_din;
    end
  end

  always_ff @(posedge clka) begin
    if (w_push) begin
      r_mem[w_wr_idx] <= channel_din;
    end
  end

  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_flit   <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_valid  <= (w_count_nxt != '0);
      if (w_count_nxt != '0) begin
        r_flit <= w_head_nxt;
      end
    end
  end

  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      r_pair_q   <= c_PAIR_IDLE;
      r_credit   <= 1'b0;
      r_overflow <= 1'b0;
      r_line_err <= 1'b0;
    end else begin
      if (w_legal) begin
        r_pair_q <= diff_pair_din;
      end
      r_credit   <= w_pop;
      // A fresh event outranks a clear in the same cycle.
      r_overflow <= w_drop   | (r_overflow & ~err_clear_din);
      r_line_err <= ~w_legal | (r_line_err & ~err_clear_din);
    end
  end

  assign flit_dout       = r_flit;
  assign flit_valid_dout = r_valid;
  assign credit_dout     = r_credit;
  assign occupancy_dout  = r_count;
  assign overflow_dout   = r_overflow;
  assign line_error_dout = r_line_err;

endmodule

`default_nettype wire

// File: tb/tb_pe_custom_inport.sv
// ============================================================================
// Module   : tb_pe_custom_inport
// Brief    : Self-checking bench: directed table, corner sequences, random run
//            against a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pe_custom_inport;

  logic        clka;
  logic        rsta;
  logic [39:0] channel_din;
  logic [1:0]  diff_pair_din;
  logic        pe_ack_din;
  logic        err_clear_din;
  logic [39:0] flit_dout;
  logic        flit_valid_dout;
  logic        credit_dout;
  logic [2:0]  occupancy_dout;
  logic        overflow_dout;
  logic        line_error_dout;

  pe_custom_inport #(.FLIT_WIDTH(40), .FIFO_DEPTH(4), .PTR_WIDTH(2)) dut (
    .clka            (clka),
    .rsta            (rsta),
    .channel_din     (channel_din),
    .diff_pair_din   (diff_pair_din),
    .pe_ack_din      (pe_ack_din),
    .err_clear_din   (err_clear_din),
    .flit_dout       (flit_dout),
    .flit_valid_dout (flit_valid_dout),
    .credit_dout     (credit_dout),
    .occupancy_dout  (occupancy_dout),
    .overflow_dout   (overflow_dout),
    .line_error_dout (line_error_dout)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [39:0] m_q[$];
  logic [1:0]  m_pair;
  logic        m_ovf, m_le, m_credit;
  logic [39:0] m_last;

  typedef struct {
    logic [1:0]  pair;
    logic [39:0] din;
    logic        ack;
    logic        clr;
    logic        ev;
    logic [39:0] ef;
    logic [2:0]  eo;
    logic        ecr;
    logic        eov;
    logic        ele;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pair   = 2'b01;
    m_ovf    = 1'b0;
    m_le     = 1'b0;
    m_credit = 1'b0;
    m_last   = '0;
  endtask

  task automatic model_step(input logic [1:0] p, input logic [39:0] d,
                            input logic a, input logic c);
    bit legal, arr, pop, push;
    legal = (p == 2'b01) || (p == 2'b10);
    arr   = legal && (p != m_pair);
    pop   = a && (m_q.size() != 0);
    push  = arr && ((m_q.size() < 4) || pop);
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back(d);
    m_credit = pop;
    m_ovf    = (arr && !push) || (m_ovf && !c);
    m_le     = !legal || (m_le && !c);
    if (legal) m_pair = p;
    if (m_q.size() != 0) m_last = m_q[0];
  endtask

  task automatic cmp_model();
    chk("valid",  64'(flit_valid_dout), 64'(m_q.size() != 0));
    chk("flit",   64'(flit_dout),       64'(m_last));
    chk("occ",    64'(occupancy_dout),  64'(m_q.size()));
    chk("credit", 64'(credit_dout),     64'(m_credit));
    chk("ovf",    64'(overflow_dout),   64'(m_ovf));
    chk("lerr",   64'(line_error_dout), 64'(m_le));
  endtask

  task automatic cyc(input logic [1:0] p, input logic [39:0] d,
                     input logic a, input logic c);
    diff_pair_din = p;
    channel_din   = d;
    pe_ack_din    = a;
    err_clear_din = c;
    @(posedge clka);
    #1;
    model_step(p, d, a, c);
    cmp_model();
  endtask

  initial begin
    logic [39:0] exp_seq[4];
    logic [63:0] t;
    logic [1:0]  p;
    rsta = 1'b0; channel_din = '0; diff_pair_din = 2'b01;
    pe_ack_din = 1'b0; err_clear_din = 1'b0;
    model_reset();
    repeat (2) @(posedge clka);
    #1;
    cmp_model();
    @(negedge clka);
    rsta = 1'b1;

    // Idle
    for (int i = 0; i < 10; i++) cyc(2'b01, 40'h0, 1'b0, 1'b0);
    chk("idle_occ", 64'(occupancy_dout), 64'd0);

    // Directed table
    tbl[0]  = '{2'b10, 40'hA5_0000_0001, 1'b0, 1'b0, 1'b1, 40'hA5_0000_0001, 3'd1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{2'b10, 40'h00_0000_0000, 1'b0, 1'b0, 1'b1, 40'hA5_0000_0001, 3'd1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{2'b10, 40'h00_0000_0000, 1'b1, 1'b0, 1'b0, 40'hA5_0000_0001, 3'd0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{2'b10, 40'h00_0000_0000, 1'b0, 1'b0, 1'b0, 40'hA5_0000_0001, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{2'b01, 40'h00_0000_000B, 1'b0, 1'b0, 1'b1, 40'h00_0000_000B, 3'd1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{2'b01, 40'h00_0000_0000, 1'b1, 1'b0, 1'b0, 40'h00_0000_000B, 3'd0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{2'b11, 40'h00_0000_00EE, 1'b0, 1'b0, 1'b0, 40'h00_0000_000B, 3'd0, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{2'b10, 40'h00_0000_00C3, 1'b0, 1'b0, 1'b1, 40'h00_0000_00C3, 3'd1, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{2'b10, 40'h00_0000_0000, 1'b1, 1'b1, 1'b0, 40'h00_0000_00C3, 3'd0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{2'b10, 40'h00_0000_0000, 1'b1, 1'b0, 1'b0, 40'h00_0000_00C3, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{2'b00, 40'h00_0000_0055, 1'b0, 1'b1, 1'b0, 40'h00_0000_00C3, 3'd0, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{2'b10, 40'h00_0000_0066, 1'b0, 1'b1, 1'b0, 40'h00_0000_00C3, 3'd0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].pair, tbl[i].din, tbl[i].ack, tbl[i].clr);
      chk($sformatf("tbl%0d_valid", i),  64'(flit_valid_dout), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d_flit", i),   64'(flit_dout),       64'(tbl[i].ef));
      chk($sformatf("tbl%0d_occ", i),    64'(occupancy_dout),  64'(tbl[i].eo));
      chk($sformatf("tbl%0d_credit", i), 64'(credit_dout),     64'(tbl[i].ecr));
      chk($sformatf("tbl%0d_ovf", i),    64'(overflow_dout),   64'(tbl[i].eov));
      chk($sformatf("tbl%0d_lerr", i),   64'(line_error_dout), 64'(tbl[i].ele));
    end

    // Overflow: five arrivals into a 4-deep FIFO, pair_q is 10 here
    for (int i = 1; i <= 5; i++) cyc((i % 2) ? 2'b01 : 2'b10, 40'(i), 1'b0, 1'b0);
    chk("ovf_occ", 64'(occupancy_dout), 64'd4);
    chk("ovf_flag", 64'(overflow_dout), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_order", 64'(flit_dout), 64'(i));
      cyc(2'b01, 40'h0, 1'b1, 1'b0);
      chk("ovf_credit", 64'(credit_dout), 64'd1);
    end
    chk("ovf_drained", 64'(flit_valid_dout), 64'd0);

    // Full FIFO with arrival coincident with ack
    cyc(2'b01, 40'h0, 1'b0, 1'b1);
    chk("clr_ovf", 64'(overflow_dout), 64'd0);
    cyc(2'b10, 40'hA, 1'b0, 1'b0);
    cyc(2'b01, 40'hB, 1'b0, 1'b0);
    cyc(2'b10, 40'hC, 1'b0, 1'b0);
    cyc(2'b01, 40'hD, 1'b0, 1'b0);
    cyc(2'b10, 40'h9, 1'b1, 1'b0);
    chk("full_occ", 64'(occupancy_dout), 64'd4);
    chk("full_noovf", 64'(overflow_dout), 64'd0);
    exp_seq[0] = 40'hB; exp_seq[1] = 40'hC; exp_seq[2] = 40'hD; exp_seq[3] = 40'h9;
    for (int i = 0; i < 4; i++) begin
      chk("wrap_order", 64'(flit_dout), 64'(exp_seq[i]));
      cyc(2'b10, 40'h0, 1'b1, 1'b0);
    end
    chk("wrap_empty", 64'(occupancy_dout), 64'd0);

    // Asynchronous reset with three flits buffered
    cyc(2'b01, 40'h31, 1'b0, 1'b0);
    cyc(2'b10, 40'h32, 1'b0, 1'b0);
    cyc(2'b01, 40'h33, 1'b0, 1'b0);
    chk("pre_rst_occ", 64'(occupancy_dout), 64'd3);
    pe_ack_din = 1'b1;
    #3 rsta = 1'b0;
    #1;
    chk("rst_valid", 64'(flit_valid_dout), 64'd0);
    chk("rst_flit",  64'(flit_dout),       64'd0);
    chk("rst_occ",   64'(occupancy_dout),  64'd0);
    repeat (2) begin
      @(posedge clka); #1;
      chk("rst_credit", 64'(credit_dout), 64'd0);
    end
    pe_ack_din = 1'b0;
    @(negedge clka);
    rsta = 1'b1;
    model_reset();
    cyc(2'b10, 40'h42, 1'b0, 1'b0);
    chk("post_rst_flit", 64'(flit_dout), 64'h42);
    chk("post_rst_occ",  64'(occupancy_dout), 64'd1);

    // Randomized run against the reference model
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0:       p = 2'b00;
        1:       p = 2'b11;
        2, 3:    p = m_pair;
        default: p = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
      endcase
      t = {$urandom(), $urandom()};
      cyc(p, t[39:0],
          (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 19) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
